// File: rtl/truth_table_sweeper.sv
// Stimulus-and-capture engine for a 3-input gate.
// It walks the gate inputs through rows 000..111 and holds each row for a
// programmable settle time. It samples the synchronised gate output once per
// row, then compares the captured truth table with an expected hex ID.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [7:0]  EXPECTED      = 8'hB6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match,
    output logic [7:0] mismatch_mask
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned TBL_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [ROW_W-1:0]   r_row;
    logic [ROW_W-1:0]   w_row_next;
    logic [ROW_W-1:0]   r_in;
    logic [ROW_W-1:0]   w_in_next;
    logic               r_busy;
    logic               w_busy_next;
    logic               r_done;
    logic               w_done_next;
    logic [TBL_W-1:0]   r_table;
    logic [TBL_W-1:0]   w_table_next;
    logic [TBL_W-1:0]   w_table_cap;
    logic               r_match;
    logic               w_match_next;
    logic [TBL_W-1:0]   r_mask;
    logic [TBL_W-1:0]   w_mask_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic               w_s_out;

    // Bring the asynchronous gate output into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= SYNC_STAGES'({r_sync, dut_out});
        end
    end

    assign w_s_out = r_sync[SYNC_STAGES-1];

    // Current table with the bit for the present row replaced by the sample (MSB = row 000).
    always_comb begin
        w_table_cap = r_table;
        w_table_cap[ROW_W'(3'd7 - r_row)] = w_s_out;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            r_in    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= '0;
            r_match <= 1'b0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_row   <= w_row_next;
            r_in    <= w_in_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_table <= w_table_next;
            r_match <= w_match_next;
            r_mask  <= w_mask_next;
        end
    end

    // Next-state and next-output logic. Abort is only honoured while sweeping.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_row_next   = r_row;
        w_in_next    = r_in;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_table_next = r_table;
        w_match_next = r_match;
        w_mask_next  = r_mask;

        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_next = SETTLE;
                    w_row_next   = '0;
                    w_in_next    = '0;
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b1;
                    w_table_next = '0;
                    w_match_next = 1'b0;
                    w_mask_next  = '0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    w_state_next = IDLE;
                    w_busy_next  = 1'b0;
                    w_in_next    = '0;
                    w_row_next   = '0;
                    w_cnt_next   = '0;
                    w_table_next = '0;
                end else if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_state_next = SAMPLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (abort) begin
                    w_state_next = IDLE;
                    w_busy_next  = 1'b0;
                    w_in_next    = '0;
                    w_row_next   = '0;
                    w_cnt_next   = '0;
                    w_table_next = '0;
                end else begin
                    w_table_next = w_table_cap;
                    if (r_row == ROW_W'(7)) begin
                        // Results are registered with the final row folded in, so they
                        // are already valid in the cycle that done pulses.
                        w_state_next = DONE;
                        w_done_next  = 1'b1;
                        w_busy_next  = 1'b0;
                        w_match_next = (w_table_cap == EXPECTED);
                        w_mask_next  = w_table_cap ^ EXPECTED;
                    end else begin
                        w_state_next = SETTLE;
                        w_row_next   = r_row + ROW_W'(1);
                        w_in_next    = r_row + ROW_W'(1);
                        w_cnt_next   = '0;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign in1           = r_in[2];
    assign in2           = r_in[1];
    assign in3           = r_in[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign table_out     = r_table;
    assign match         = r_match;
    assign mismatch_mask = r_mask;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper.
// The main instance uses SETTLE_CYCLES=4 and drives a gate model selected
// by mode. Two further instances drive a gate with a 3-cycle output delay,
// using SETTLE_CYCLES=2 and SETTLE_CYCLES=8.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0 gate 0xB6, 1 tied low, 2 tied high, 3 inverted gate

    // main instance signals
    logic       start_a = 1'b0, abort_a = 1'b0, dut_out_a;
    logic       in1_a, in2_a, in3_a, busy_a, done_a, match_a;
    logic [7:0] table_a, mask_a;

    // slow-gate instances signals
    logic       start_s = 1'b0, abort_s = 1'b0;
    logic       dut_out_s2, in1_s2, in2_s2, in3_s2, busy_s2, done_s2, match_s2;
    logic [7:0] table_s2, mask_s2;
    logic       dut_out_s8, in1_s8, in2_s8, in3_s8, busy_s8, done_s8, match_s8;
    logic [7:0] table_s8, mask_s8;
    logic [2:0] d2_a = 3'd0, d2_b = 3'd0, d2_c = 3'd0;
    logic [2:0] d8_a = 3'd0, d8_b = 3'd0, d8_c = 3'd0;

    function automatic logic gate_b6(input logic [2:0] r);
        logic [7:0] lut;
        lut = 8'hB6;
        return lut[3'(3'd7 - r)];
    endfunction

    always_comb begin
        case (mode)
            1:       dut_out_a = 1'b0;
            2:       dut_out_a = 1'b1;
            3:       dut_out_a = ~gate_b6({in1_a, in2_a, in3_a});
            default: dut_out_a = gate_b6({in1_a, in2_a, in3_a});
        endcase
    end

    // 3-cycle delayed gate models
    always @(posedge clk) begin
        d2_a <= {in1_s2, in2_s2, in3_s2};
        d2_b <= d2_a;
        d2_c <= d2_b;
        d8_a <= {in1_s8, in2_s8, in3_s8};
        d8_b <= d8_a;
        d8_c <= d8_b;
    end
    assign dut_out_s2 = gate_b6(d2_c);
    assign dut_out_s8 = gate_b6(d8_c);

    truth_table_sweeper #(.SETTLE_CYCLES(4), .SYNC_STAGES(2), .EXPECTED(8'hB6)) u_dut (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .dut_out(dut_out_a),
        .in1(in1_a), .in2(in2_a), .in3(in3_a), .busy(busy_a), .done(done_a),
        .table_out(table_a), .match(match_a), .mismatch_mask(mask_a)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(2), .SYNC_STAGES(2), .EXPECTED(8'hB6)) u_slow2 (
        .clk(clk), .reset(reset), .start(start_s), .abort(abort_s), .dut_out(dut_out_s2),
        .in1(in1_s2), .in2(in2_s2), .in3(in3_s2), .busy(busy_s2), .done(done_s2),
        .table_out(table_s2), .match(match_s2), .mismatch_mask(mask_s2)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(8), .SYNC_STAGES(2), .EXPECTED(8'hB6)) u_slow8 (
        .clk(clk), .reset(reset), .start(start_s), .abort(abort_s), .dut_out(dut_out_s8),
        .in1(in1_s8), .in2(in2_s8), .in3(in3_s8), .busy(busy_s8), .done(done_s8),
        .table_out(table_s8), .match(match_s8), .mismatch_mask(mask_s8)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // One sweep on the main instance; caller is 1 time unit after a rising edge.
    // Cycle 0 is the cycle start is driven; rows last 5 cycles, done expected at 41.
    task automatic run_sweep(input int restart_cyc, input int abort_cyc,
                             output int done_cyc, output int n_done,
                             output int row_errs, output int busy_errs);
        logic [2:0] exp_row;
        done_cyc  = -1;
        n_done    = 0;
        row_errs  = 0;
        busy_errs = 0;
        start_a   = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            start_a = (k == restart_cyc);
            abort_a = (k == abort_cyc);
            exp_row = (k >= 41) ? 3'd7 : 3'((k - 1) / 5);
            if ({in1_a, in2_a, in3_a} != exp_row) row_errs++;
            if (busy_a != (k <= 40)) busy_errs++;
            if (done_a) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k;
            end
        end
        start_a = 1'b0;
        abort_a = 1'b0;
    endtask

    typedef struct {
        int         mode;
        int         restart_cyc;
        int         abort_cyc;
        logic [7:0] exp_table;
        logic       exp_match;
        logic [7:0] exp_mask;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int dc, nd, re, be, first_done, second_done, n_pulses;

        vecs[0] = '{0,  0,  0, 8'hB6, 1'b1, 8'h00};  // real gate
        vecs[1] = '{1,  0,  0, 8'h00, 1'b0, 8'hB6};  // tied low
        vecs[2] = '{2,  0,  0, 8'hFF, 1'b0, 8'h49};  // tied high
        vecs[3] = '{3,  0,  0, 8'h49, 1'b0, 8'hFF};  // inverted gate
        vecs[4] = '{0, 17,  0, 8'hB6, 1'b1, 8'h00};  // start again during row 3
        vecs[5] = '{0,  0, 41, 8'hB6, 1'b1, 8'h00};  // abort in DONE

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({in1_a, in2_a, in3_a, busy_a, done_a, table_a, match_a, mask_a}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            mode = vecs[i].mode;
            @(posedge clk); #1;
            run_sweep(vecs[i].restart_cyc, vecs[i].abort_cyc, dc, nd, re, be);
            check($sformatf("v%0d_done_cycle", i), 32'(dc), 32'd41);
            check($sformatf("v%0d_done_count", i), 32'(nd), 32'd1);
            check($sformatf("v%0d_row_seq_errs", i), 32'(re), 32'd0);
            check($sformatf("v%0d_busy_errs", i), 32'(be), 32'd0);
            check($sformatf("v%0d_table", i), 32'(table_a), 32'(vecs[i].exp_table));
            check($sformatf("v%0d_match", i), 32'(match_a), 32'(vecs[i].exp_match));
            check($sformatf("v%0d_mask", i), 32'(mask_a), 32'(vecs[i].exp_mask));
        end
        mode = 0;

        // abort while row 5 is being driven
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (26) @(posedge clk);
        #1;
        check("abort_pre_row", 32'({in1_a, in2_a, in3_a}), 32'd5);
        check("abort_pre_table", 32'(table_a), 32'hB0);
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_inputs", 32'({in1_a, in2_a, in3_a}), 32'd0);
        check("abort_table", 32'(table_a), 32'd0);
        nd = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (done_a) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        run_sweep(0, 0, dc, nd, re, be);
        check("post_abort_done_cycle", 32'(dc), 32'd41);
        check("post_abort_table", 32'(table_a), 32'hB6);

        // start and abort together in IDLE: abort wins
        start_a = 1'b1;
        abort_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        abort_a = 1'b0;
        be = 0;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy_a) be++;
            if (done_a) nd++;
            @(posedge clk); #1;
        end
        check("start_abort_busy", 32'(be), 32'd0);
        check("start_abort_done", 32'(nd), 32'd0);
        check("start_abort_inputs", 32'({in1_a, in2_a, in3_a}), 32'd7);

        // asynchronous reset during row 2
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("rst_pre_row", 32'({in1_a, in2_a, in3_a}), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_outputs", 32'({in1_a, in2_a, in3_a, busy_a, done_a, table_a, match_a, mask_a}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (done_a || busy_a) nd++;
        end
        check("rst_no_activity", 32'(nd), 32'd0);
        run_sweep(0, 0, dc, nd, re, be);
        check("post_rst_done_count", 32'(nd), 32'd1);
        check("post_rst_table", 32'(table_a), 32'hB6);
        check("post_rst_match", 32'(match_a), 32'd1);

        // start held high: second sweep begins right after DONE
        first_done  = -1;
        second_done = -1;
        n_pulses    = 0;
        start_a     = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk); #1;
            if (k == 83) start_a = 1'b0;
            if (k == 43) check("held_busy_restart", 32'(busy_a), 32'd1);
            if (done_a) begin
                n_pulses++;
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
        end
        start_a = 1'b0;
        check("held_first_done", 32'(first_done), 32'd41);
        check("held_second_done", 32'(second_done), 32'd83);
        check("held_pulses", 32'(n_pulses), 32'd2);

        // 3-cycle gate delay: too short vs long enough settle time
        first_done  = -1;
        second_done = -1;
        start_s     = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            start_s = 1'b0;
            if (done_s2 && first_done < 0) first_done = k;
            if (done_s8 && second_done < 0) second_done = k;
        end
        check("slow2_done_cycle", 32'(first_done), 32'd25);
        check("slow8_done_cycle", 32'(second_done), 32'd73);
        check("slow2_match", 32'(match_s2), 32'd0);
        check("slow2_table", 32'(table_s2), 32'hDB);
        check("slow2_mask", 32'(mask_s2), 32'h6D);
        check("slow8_match", 32'(match_s8), 32'd1);
        check("slow8_table", 32'(table_s8), 32'hB6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
